// File: rtl/melody_sequencer.sv
// Song ROM walker: times each note, inserts an articulation gap, handles stop and loop.
module melody_sequencer #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned FREQ_W   = 13,
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned GAP_CYC  = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [FREQ_W+7:0] rom_data,
  output logic              ring,
  output logic [FREQ_W-1:0] freq,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                ring_q, ring_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [7:0]          dur_q, dur_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                adv_c;
  logic                end_c;

  wire [FREQ_W-1:0] data_freq_c = rom_data[FREQ_W+7:8];
  wire [7:0]        data_dur_c  = rom_data[7:0];

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      ring_q     <= 1'b0;
      freq_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tick_q     <= '0;
      dur_q      <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      ring_q     <= ring_d;
      freq_q     <= freq_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tick_q     <= tick_d;
      dur_q      <= dur_d;
      gap_q      <= gap_d;
    end
  end

  // Next-state and output logic; stop overrides everything outside IDLE
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    ring_d     = ring_q;
    freq_d     = freq_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tick_d     = tick_q;
    dur_d      = dur_q;
    gap_d      = gap_q;
    adv_c      = 1'b0;
    end_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          rom_addr_d = '0;
          busy_d     = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (data_dur_c == 8'd0) begin
          end_c = 1'b1;
        end else begin
          freq_d  = data_freq_c;
          ring_d  = (data_freq_c != '0);
          tick_d  = '0;
          dur_d   = data_dur_c;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          dur_d  = dur_q - 8'd1;
          if (dur_q == 8'd1) begin
            ring_d = 1'b0;
            if (GAP_CYC != 0) begin
              gap_d   = '0;
              state_d = S_GAP;
            end else begin
              adv_c = 1'b1;
            end
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          adv_c = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Step to the next word; running off the last address ends the song
    if (adv_c) begin
      if (rom_addr_q == ADDR_LAST) begin
        end_c = 1'b1;
      end else begin
        rom_addr_d = rom_addr_q + ADDR_W'(1);
        state_d    = S_FETCH;
      end
    end

    // End of song: loop back to the top or finish with a done pulse
    if (end_c) begin
      rom_addr_d = '0;
      if (loop_en) begin
        state_d = S_FETCH;
      end else begin
        ring_d  = 1'b0;
        freq_d  = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
    end

    if (stop && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      rom_addr_d = '0;
      ring_d     = 1'b0;
      freq_d     = '0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  assign rom_addr = rom_addr_q;
  assign ring     = ring_q;
  assign freq     = freq_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: song-timeline model, per-cycle compare, random songs.
module tb_melody_sequencer;

  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned FREQ_W   = 13;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned GAP_CYC  = 2;
  localparam int unsigned DEPTH    = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [FREQ_W+7:0] rom_data;
  logic              ring;
  logic [FREQ_W-1:0] freq;
  logic              busy;
  logic              done;

  melody_sequencer #(
    .ADDR_W(ADDR_W), .FREQ_W(FREQ_W), .TICK_DIV(TICK_DIV), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .ring(ring), .freq(freq),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song ROM with one cycle of read latency
  logic [FREQ_W-1:0] song_f [DEPTH];
  logic [7:0]        song_d [DEPTH];
  always_ff @(posedge clk) rom_data <= {song_f[rom_addr], song_d[rom_addr]};

  typedef struct packed {
    logic              ring;
    logic [FREQ_W-1:0] freq;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t tl[$];        // expected outputs after each edge following start
  bit   lsched[$];    // loop_en driven during each timeline cycle
  bit   loop_dec[$];  // loop decisions for successive end-of-song points
  exp_t exp_cur;
  bit   check_en;
  int   n_checks;
  int   n_pass;

  task automatic chk(input string name, input int unsigned act, input int unsigned expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("ring", 32'(ring), 32'(exp_cur.ring));
      chk("freq", 32'(freq), 32'(exp_cur.freq));
      chk("busy", 32'(busy), 32'(exp_cur.busy));
      chk("done", 32'(done), 32'(exp_cur.done));
      chk("rom_addr", 32'(rom_addr), 32'(exp_cur.addr));
    end
  end

  function automatic void emit(bit r, int unsigned f, bit b, bit d, int unsigned a);
    exp_t e;
    e.ring = r; e.freq = FREQ_W'(f); e.busy = b; e.done = d; e.addr = ADDR_W'(a);
    tl.push_back(e);
    lsched.push_back(1'($urandom));
  endfunction

  // Song played as a list of phases: wait, load, note, gap, repeat
  function automatic void build_model();
    int unsigned addr = 0;
    int unsigned cur  = 0;
    bit fin = 0;
    bit at_end;
    bit dec;
    tl.delete();
    lsched.delete();
    while (!fin && tl.size() < 4000) begin
      emit(0, cur, 1, 0, addr);
      emit(0, cur, 1, 0, addr);
      if (song_d[addr] == 8'd0) begin
        at_end = 1;
      end else begin
        cur = song_f[addr];
        repeat (int'(song_d[addr]) * TICK_DIV) emit(cur != 0, cur, 1, 0, addr);
        repeat (GAP_CYC) emit(0, cur, 1, 0, addr);
        at_end = (addr == DEPTH - 1);
        if (!at_end) addr++;
      end
      if (at_end) begin
        dec = (loop_dec.size() > 0) ? loop_dec.pop_front() : 1'b0;
        lsched[lsched.size()-1] = dec;
        if (dec) addr = 0;
        else begin
          emit(0, 0, 0, 1, 0);
          fin = 1;
        end
      end
    end
  endfunction

  function automatic int first_ring();
    for (int i = 0; i < tl.size(); i++) if (tl[i].ring) return i;
    return -1;
  endfunction

  task automatic idle_cycles(input int n);
    exp_cur = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // stop_at: -1 none, -2 random, else timeline index of the stop cycle
  task automatic run_song(input int stop_at, input bit noise);
    int sa = stop_at;
    build_model();
    if (tl.size() >= 4000) chk("model_terminates", tl.size(), 0);
    if (sa == -2) sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, tl.size() - 2)) : -1;
    start = 1'b1; stop = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < tl.size(); t++) begin
      exp_cur = tl[t];
      loop_en = lsched[t];
      start   = noise && tl[t].busy && ($urandom_range(0, 5) == 0);
      stop    = (t == sa);
      @(posedge clk); #1;
      if (t == sa) break;
    end
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    idle_cycles(3);
  endtask

  task automatic load_basic();
    for (int i = 0; i < DEPTH; i++) begin song_f[i] = '0; song_d[i] = '0; end
    song_f[0] = 13'd10; song_d[0] = 8'd2;
    song_f[1] = 13'd20; song_d[1] = 8'd1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; check_en = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; exp_cur = '0;
    load_basic();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ring", 32'(ring), 0);
    chk("rst_freq", 32'(freq), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_en = 1;
    idle_cycles(2);

    // Basic song, with literal pins on the model's timeline
    load_basic();
    build_model();
    chk("model_basic_len", tl.size(), 23);
    chk("model_basic_first_ring", 32'(first_ring()), 2);
    chk("model_basic_done_idx", 32'(tl[22].done), 1);
    chk("model_basic_note2_freq", 32'(tl[14].freq), 20);
    run_song(-1, 0);

    // Rest then a note
    for (int i = 0; i < DEPTH; i++) begin song_f[i] = '0; song_d[i] = '0; end
    song_d[0] = 8'd3; song_f[1] = 13'd15; song_d[1] = 8'd1;
    build_model();
    chk("model_rest_first_ring", 32'(first_ring()), 18);
    run_song(-1, 1);

    // Loop twice, then let the third marker finish the song
    load_basic();
    loop_dec = '{1'b1, 1'b1};
    build_model();
    chk("model_loop_len", tl.size(), 67);
    loop_dec = '{1'b1, 1'b1};
    run_song(-1, 1);

    // Stop during note 2, then replay from the top
    load_basic();
    run_song(15, 0);
    run_song(-1, 0);

    // start and stop together while idle
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    idle_cycles(3);

    // Full ROM without an end marker
    for (int i = 0; i < DEPTH; i++) begin song_f[i] = 13'(100 + i); song_d[i] = 8'd1; end
    build_model();
    chk("model_full_len", tl.size(), 65);
    chk("model_full_last_addr", 32'(tl[61].addr), 7);
    run_song(-1, 1);

    // Async reset in the middle of a ringing note
    load_basic();
    build_model();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 5; t++) begin exp_cur = tl[t]; @(posedge clk); #1; end
    check_en = 0;
    #2;
    chk("pre_rst_ring", 32'(ring), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ring", 32'(ring), 0);
    chk("async_rst_freq", 32'(freq), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_done", 32'(done), 0);
    chk("async_rst_addr", 32'(rom_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cur = '0;
    #1;
    check_en = 1;
    idle_cycles(2);

    // Random songs with random loops, stops and ignored starts
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        song_f[i] = ($urandom_range(0, 4) == 0) ? 13'd0 : 13'($urandom_range(1, 8191));
        song_d[i] = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
      end
      loop_dec.delete();
      repeat ($urandom_range(0, 2)) loop_dec.push_back(1'b1);
      run_song(-2, 1);
    end

    check_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Plays a stored song by driving one note player's `ring`/`freq` inputs.
- Walks an external synchronous song ROM. Each word holds a note frequency code and a duration.
- Times each note, inserts a silent articulation gap between notes, and supports stop and loop.
- Sits between the piano top-level control (start/stop buttons) and the single shared note player.

Parameters:
- ADDR_W, 6: song ROM address width; the song holds at most 2^ADDR_W entries.
- FREQ_W, 13: width of the frequency code passed to the note player.
- TICK_DIV, 1000: clk cycles per duration unit; must be >= 1.
- GAP_CYC, 100: clk cycles with `ring` low after each note; 0 is allowed.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to play from address 0; ignored while busy.
- stop  in  1  single-cycle abort; valid in any state.
- loop_en  in  1  level; sampled when the end of the song is reached.
- rom_addr  out  ADDR_W  song ROM address (registered).
- rom_data  in  FREQ_W+8  {freq[FREQ_W-1:0], dur[7:0]}; valid the cycle after rom_addr changes.
- ring  out  1  note enable to the note player (registered).
- freq  out  FREQ_W  frequency code to the note player (registered).
- busy  out  1  high while a song is in progress.
- done  out  1  one-cycle pulse on normal song completion.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rom_addr=0, ring=0, freq=0, busy=0, done=0.
  - All counters cleared.
- States: IDLE, FETCH, LOAD, PLAY, GAP, DONE.
- IDLE:
  - busy=0, ring=0.
  - start=1 with stop=0 -> rom_addr<=0, busy<=1, go FETCH.
- FETCH: one wait cycle for ROM latency, then go LOAD.
- LOAD: sample rom_data.
  - dur==0 (end marker):
    - loop_en=1 -> rom_addr<=0, go FETCH.
    - loop_en=0 -> go DONE.
  - dur!=0:
    - freq<=data freq, ring<=(data freq!=0), tick_cnt<=0, dur_cnt<=dur.
    - Go PLAY.
    - A freq code of 0 is a rest: ring stays 0, timing is identical to a note.
- PLAY:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - On each wrap dur_cnt decrements.
  - The wrap with dur_cnt==1 ends the note: ring<=0.
    - GAP_CYC>0 -> go GAP.
    - GAP_CYC==0 -> advance address.
  - Note length is exactly dur*TICK_DIV cycles.
- GAP:
  - ring=0, freq holds its last value.
  - After GAP_CYC cycles, advance address.
- Advance address:
  - rom_addr<2^ADDR_W-1 -> rom_addr+1, go FETCH.
  - rom_addr==2^ADDR_W-1 -> treat as an end marker (same loop_en rule; loop restarts at 0).
- DONE:
  - done=1 for exactly one cycle; ring=0, freq<=0, busy<=0, rom_addr<=0.
  - Go IDLE.
- Latency:
  - start sampled at edge E -> ring/freq valid after edge E+2.
  - Between consecutive notes, ring is low for GAP_CYC+2 cycles (GAP, FETCH, LOAD).
- stop=1 in any non-IDLE state:
  - At the next edge: ring=0, freq=0, busy=0, rom_addr=0, state=IDLE.
  - No done pulse.
- Priority and ignored inputs:
  - stop and start in the same cycle -> stop wins, stays/returns IDLE.
  - start while busy -> ignored.
  - loop_en changes mid-note -> no effect until the next end-of-song decision.
- Widths:
  - tick_cnt holds TICK_DIV-1; gap_cnt holds GAP_CYC.
  - dur_cnt is 8 bit; dur=255 is legal.
  - No counter overflow is permitted.

Test Plan (TICK_DIV=4, GAP_CYC=2, ADDR_W=3):
- Reset: assert rst_n=0 mid-note with ring=1 -> ring, freq, busy, done, rom_addr all 0 immediately, without waiting for a clk edge.
- Basic song: ROM {10,2},{20,1},{0,0}; start pulse.
  - ring=1 with freq=10 for 8 cycles starting 2 edges after start.
  - Then ring=0 for 4 cycles.
  - Then ring=1 with freq=20 for 4 cycles.
  - Then done=1 for one cycle, busy=0, freq=0.
- Rest: ROM {0,3},{15,1},{0,0} -> ring=0 and freq=0 for 12+4 cycles, then ring=1 with freq=15 for 4 cycles.
- Loop: same ROM as the basic song, loop_en=1 -> after the {0,0} marker, rom_addr returns to 0 and freq=10 replays. No done pulse while loop_en=1. Dropping loop_en ends the song at the next marker with a done pulse.
- Stop:
  - stop mid-PLAY of note 2 -> next cycle ring=0, freq=0, busy=0, no done.
  - A following start replays from address 0.
  - start+stop in the same cycle -> stays IDLE.
- Full ROM: 8 non-zero entries, no marker -> all 8 notes play in order, then done pulse after address 7. rom_addr never wraps mid-song.
